// File: rtl/fft8_iter_core.sv
// fft8_iter_core: 8-point radix-2 DIT FFT/IFFT streaming engine built on one time-shared butterfly.
// Define FFT_BITREV_OUT_EN to unload bins in bit-reversed order (0,4,2,6,1,5,3,7).
module fft8_iter_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned PW = DATA_W + TW_W + 1;
  localparam int unsigned SW = DATA_W + 2;
  localparam logic signed [TW_W-1:0] TW_ONE = {1'b0, {(TW_W - 1){1'b1}}};
  localparam logic signed [TW_W-1:0] TW_C   =
      TW_W'($rtoi(0.70710678 * (2.0 ** (TW_W - 1)) + 0.5));
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 2);

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  state_e state_q, state_d;
  logic [2:0] load_cnt_q, unl_cnt_q, step_q;
  logic [1:0] stage_q;
  logic       inv_q;

  logic [DATA_W-1:0] mem_re [8];
  logic [DATA_W-1:0] mem_im [8];

  logic       load_fire, out_fire, issue, last_bf;
  logic [1:0] j, tw_exp;
  logic [2:0] top, bot, rd_addr;

  logic signed [TW_W-1:0] w_re, w_im, w_im_raw;
  logic signed [PW-1:0]   b_re_x, b_im_x, w_re_x, w_im_x, prod_re, prod_im;
  logic signed [SW-1:0]   p_re, p_im;

  logic                 s1_valid_q;
  logic [2:0]           s1_top_q, s1_bot_q;
  logic signed [SW-1:0] s1_a_re_q, s1_a_im_q, s1_p_re_q, s1_p_im_q;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StUnload);
  assign busy      = (state_q != StLoad);
  assign load_fire = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign issue     = (state_q == StCompute) && !step_q[2];
  assign last_bf   = (stage_q == 2'd2) && (step_q == 3'd5);
  assign j         = step_q[1:0];

`ifdef FFT_BITREV_OUT_EN
  assign rd_addr = bitrev3(unl_cnt_q);
`else
  assign rd_addr = unl_cnt_q;
`endif

  assign out_re   = out_valid ? mem_re[rd_addr] : '0;
  assign out_im   = out_valid ? mem_im[rd_addr] : '0;
  assign out_idx  = out_valid ? rd_addr : 3'd0;
  assign out_last = out_valid && (unl_cnt_q == 3'd7);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (load_fire && load_cnt_q == 3'd7) state_d = StCompute;
      StCompute: if (last_bf) state_d = StUnload;
      StUnload:  if (out_fire && unl_cnt_q == 3'd7) state_d = StLoad;
      default:   state_d = StLoad;
    endcase
  end

  // Butterfly j of a stage: span = 1<<stage, twiddle exponent = k*(4/span).
  always_comb begin
    top    = 3'd0;
    tw_exp = 2'd0;
    unique case (stage_q)
      2'd0: begin
        top    = {j, 1'b0};
        bot    = top | 3'd1;
      end
      2'd1: begin
        top    = {j[1], 1'b0, j[0]};
        bot    = top | 3'd2;
        tw_exp = {j[0], 1'b0};
      end
      default: begin
        top    = {1'b0, j};
        bot    = top | 3'd4;
        tw_exp = j;
      end
    endcase
  end

  always_comb begin
    w_re     = TW_ONE;
    w_im_raw = '0;
    unique case (tw_exp)
      2'd0: begin w_re = TW_ONE; w_im_raw = '0;      end
      2'd1: begin w_re = TW_C;   w_im_raw = -TW_C;   end
      2'd2: begin w_re = '0;     w_im_raw = -TW_ONE; end
      default: begin w_re = -TW_C; w_im_raw = -TW_C; end
    endcase
    w_im = inv_q ? -w_im_raw : w_im_raw;
  end

  always_comb begin
    b_re_x  = PW'($signed(mem_re[bot]));
    b_im_x  = PW'($signed(mem_im[bot]));
    w_re_x  = PW'(w_re);
    w_im_x  = PW'(w_im);
    prod_re = b_re_x * w_re_x - b_im_x * w_im_x + RND;
    prod_im = b_re_x * w_im_x + b_im_x * w_re_x + RND;
    if (tw_exp == 2'd0) begin
      // Unity twiddle passes b through exactly, avoiding the (1 - 2^-(TW_W-1)) gain.
      p_re = SW'($signed(mem_re[bot]));
      p_im = SW'($signed(mem_im[bot]));
    end else begin
      p_re = SW'(prod_re >>> (TW_W - 1));
      p_im = SW'(prod_im >>> (TW_W - 1));
    end
  end

  assign sum_re = s1_a_re_q + s1_p_re_q;
  assign sum_im = s1_a_im_q + s1_p_im_q;
  assign dif_re = s1_a_re_q - s1_p_re_q;
  assign dif_im = s1_a_im_q - s1_p_im_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      unl_cnt_q  <= '0;
      step_q     <= '0;
      stage_q    <= '0;
      inv_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_top_q   <= '0;
      s1_bot_q   <= '0;
      s1_a_re_q  <= '0;
      s1_a_im_q  <= '0;
      s1_p_re_q  <= '0;
      s1_p_im_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_fire) begin
        load_cnt_q <= load_cnt_q + 3'd1;
        if (load_cnt_q == 3'd0) inv_q <= in_inv;
      end
      if (state_q == StCompute) begin
        if (step_q == 3'd5) begin
          step_q  <= '0;
          stage_q <= last_bf ? 2'd0 : stage_q + 2'd1;
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
      if (out_fire) unl_cnt_q <= unl_cnt_q + 3'd1;
      s1_valid_q <= issue;
      if (issue) begin
        s1_top_q  <= top;
        s1_bot_q  <= bot;
        s1_a_re_q <= SW'($signed(mem_re[top]));
        s1_a_im_q <= SW'($signed(mem_im[top]));
        s1_p_re_q <= p_re;
        s1_p_im_q <= p_im;
      end
    end
  end

  // Storage holds samples in bit-reversed order so the in-place DIT leaves bins in natural order.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[bitrev3(load_cnt_q)] <= in_re;
      mem_im[bitrev3(load_cnt_q)] <= in_im;
    end
    if (s1_valid_q) begin
      mem_re[s1_top_q] <= DATA_W'(sum_re >>> 1);
      mem_im[s1_top_q] <= DATA_W'(sum_im >>> 1);
      mem_re[s1_bot_q] <= DATA_W'(dif_re >>> 1);
      mem_im[s1_bot_q] <= DATA_W'(dif_im >>> 1);
    end
  end

endmodule

// File: tb/tb_fft8_iter_core.sv
// Self-checking bench for fft8_iter_core: directed frames plus random frames against an
// array-based fixed-point FFT model.
module tb_fft8_iter_core;

  logic        clk, reset;
  logic        in_valid, in_ready, in_inv;
  logic        out_valid, out_ready, out_last, busy;
  logic [15:0] in_re, in_im, out_re, out_im;
  logic [2:0]  out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  longint tw_re[4] = '{32767, 23170, 0, -23170};
  longint tw_im[4] = '{0, -23170, -32767, -23170};

  fft8_iter_core #(.DATA_W(16), .TW_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bitrev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  // Textbook iterative DIT FFT with the engine's per-stage rounding and 1/2 scaling.
  task automatic model_fft(input bit inv, input longint xr[8], input longint xi[8],
                           output longint yr[8], output longint yi[8]);
    longint ar[8], ai[8];
    for (int n = 0; n < 8; n++) begin
      ar[bitrev3(n)] = xr[n];
      ai[bitrev3(n)] = xi[n];
    end
    for (int s = 0; s < 3; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < 8; g += 2 * span) begin
        for (int k = 0; k < span; k++) begin
          int e, t, b;
          longint wr, wi, pr, pi, at_r, at_i;
          e  = k * (4 / span);
          t  = g + k;
          b  = t + span;
          wr = tw_re[e];
          wi = inv ? -tw_im[e] : tw_im[e];
          if (e == 0) begin
            pr = ar[b];
            pi = ai[b];
          end else begin
            pr = (ar[b] * wr - ai[b] * wi + 16384) >>> 15;
            pi = (ar[b] * wi + ai[b] * wr + 16384) >>> 15;
          end
          at_r  = ar[t];
          at_i  = ai[t];
          ar[t] = wrap16((at_r + pr) >>> 1);
          ai[t] = wrap16((at_i + pi) >>> 1);
          ar[b] = wrap16((at_r - pr) >>> 1);
          ai[b] = wrap16((at_i - pi) >>> 1);
        end
      end
    end
    yr = ar;
    yi = ai;
  endtask

  task automatic send_frame(input string tag, input bit inv, input longint xr[8],
                            input longint xi[8], input bit gaps);
    int n, guard;
    n = 0;
    guard = 0;
    while (n < 8 && guard < 500) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_re    = 16'(xr[n]);
      in_im    = 16'(xi[n]);
      in_inv   = (n == 0) ? inv : 1'($urandom_range(0, 1));
      if (in_valid && in_ready) n++;
    end
    if (n < 8) check_eq({tag, "_load_timeout"}, n, 8);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_rdy_cmp"}, in_ready, 0);
  endtask

  task automatic recv_frame(input string tag, input longint er[8], input longint ei[8],
                            input int stall_at, input bit rnd,
                            output longint gr[8], output longint gi[8]);
    int k, guard, first, stall_left, idx;
    k = 0;
    guard = 0;
    first = -1;
    stall_left = 20;
    for (int i = 0; i < 8; i++) begin
      gr[i] = 0;
      gi[i] = 0;
    end
    while (k < 8 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (out_valid && k == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      check_eq({tag, "_rdy_busy"}, in_ready, 0);
      if (out_valid) begin
        if (first < 0) begin
          first = guard;
          check_eq({tag, "_lat"}, first, 18);
        end
`ifdef FFT_BITREV_OUT_EN
        idx = bitrev3(k);
`else
        idx = k;
`endif
        check_eq({tag, "_idx"}, out_idx, idx);
        check_eq({tag, "_last"}, out_last, (k == 7));
        check_eq({tag, "_re"}, $signed(out_re), er[idx]);
        check_eq({tag, "_im"}, $signed(out_im), ei[idx]);
        gr[idx] = longint'($signed(out_re));
        gi[idx] = longint'($signed(out_im));
        if (out_ready) k++;
      end
    end
    if (k < 8) check_eq({tag, "_unload_timeout"}, k, 8);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_post_valid"}, out_valid, 0);
    check_eq({tag, "_post_ready"}, in_ready, 1);
    check_eq({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    longint xr[8], xi[8], er[8], ei[8], gr[8], gi[8];
    longint tone_re[8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
    longint tone_im[8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
    bit     inv;
    longint er_b, ei_b;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_re", out_re, 0);
    check_eq("rst_out_im", out_im, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Impulse, FFT.
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n == 0) ? 800 : 0;
      xi[n] = 0;
      er[n] = 100;
      ei[n] = 0;
    end
    send_frame("imp_fft", 1'b0, xr, xi, 1'b0);
    recv_frame("imp_fft", er, ei, -1, 1'b0, gr, gi);

    // DC, FFT.
    for (int n = 0; n < 8; n++) begin
      xr[n] = 800;
      xi[n] = 0;
      er[n] = (n == 0) ? 800 : 0;
      ei[n] = 0;
    end
    send_frame("dc_fft", 1'b0, xr, xi, 1'b0);
    recv_frame("dc_fft", er, ei, -1, 1'b0, gr, gi);

    // Impulse, IFFT.
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n == 0) ? 800 : 0;
      xi[n] = 0;
      er[n] = 100;
      ei[n] = 0;
    end
    send_frame("imp_ifft", 1'b1, xr, xi, 1'b0);
    recv_frame("imp_ifft", er, ei, -1, 1'b0, gr, gi);

    // Full-scale tone at bin 1.
    model_fft(1'b0, tone_re, tone_im, er, ei);
    send_frame("tone", 1'b0, tone_re, tone_im, 1'b0);
    recv_frame("tone", er, ei, -1, 1'b0, gr, gi);
    for (int b = 0; b < 8; b++) begin
      er_b = (b == 1) ? gr[b] - 32767 : gr[b];
      ei_b = gi[b];
      check_eq("tone_tol_re", (er_b <= 2 && er_b >= -2), 1);
      check_eq("tone_tol_im", (ei_b <= 2 && ei_b >= -2), 1);
    end

    // Random frames with input gaps and output backpressure; frame 2 stalls 20 cycles.
    for (int f = 0; f < 6; f++) begin
      inv = 1'($urandom_range(0, 1));
      for (int n = 0; n < 8; n++) begin
        xr[n] = longint'($signed(16'($urandom)));
        xi[n] = longint'($signed(16'($urandom)));
      end
      model_fft(inv, xr, xi, er, ei);
      send_frame("rnd", inv, xr, xi, 1'b1);
      recv_frame("rnd", er, ei, (f == 2) ? 3 : -1, 1'b1, gr, gi);
    end

    // Reset during COMPUTE discards the frame; a clean impulse frame follows.
    for (int n = 0; n < 8; n++) begin
      xr[n] = longint'($signed(16'($urandom)));
      xi[n] = longint'($signed(16'($urandom)));
    end
    send_frame("rst_mid", 1'b0, xr, xi, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", out_valid, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n == 0) ? 800 : 0;
      xi[n] = 0;
      er[n] = 100;
      ei[n] = 0;
    end
    send_frame("after_rst", 1'b0, xr, xi, 1'b0);
    recv_frame("after_rst", er, ei, -1, 1'b0, gr, gi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft8_iter_core.md
Name: fft8_iter_core

Overview:
- Parametrised 8-point radix-2 DIT FFT/IFFT engine built around one time-shared butterfly.
- Successor to the fully parallel fixed-16-bit FFT→IFFT chain.
- Adds:
  - Sample-serial complex streaming with valid/ready on both sides.
  - Per-frame forward/inverse mode select.
  - Configurable data and twiddle widths.
- Sits between a sample source and downstream spectral or time-domain consumers.

Parameters:
- DATA_W, 16: signed width of re/im for input, internal storage and output.
- TW_W, 16: signed twiddle width, Q1.(TW_W-1); c = round(0.70710678·2^(TW_W-1)), which is 23170 for TW_W=16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state while 0.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample this cycle.
- in_re  in  DATA_W  input real part, signed.
- in_im  in  DATA_W  input imaginary part, signed.
- in_inv  in  1  mode, sampled with sample 0 of a frame: 0 = FFT, 1 = IFFT.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts the output sample.
- out_re  out  DATA_W  output real part.
- out_im  out  DATA_W  output imaginary part.
- out_idx  out  3  bin or time index of the current output.
- out_last  out  1  high with the 8th output of a frame.
- busy  out  1  high in COMPUTE and UNLOAD.

Behaviour:
- Reset values (reset=0, asynchronous):
  - State = LOAD; load, butterfly and unload counters = 0; butterfly pipeline valid bits = 0.
  - in_ready=1; out_valid=0; out_re=0, out_im=0, out_idx=0, out_last=0; busy=0.
  - Memory contents are don't-care.
  - A partial frame in flight is discarded. No output appears until a full new frame has been loaded.
- Storage: 8×(2·DATA_W) register array.
  - Sample n (natural order) is written to address bitrev3(n).
- LOAD:
  - in_ready=1. A sample transfers when in_valid & in_ready.
  - in_inv is latched on the transfer of sample 0.
  - After sample 7 transfers → COMPUTE on the next cycle; in_ready drops.
- COMPUTE: 3 stages × 4 butterflies.
  - One butterfly is issued per cycle.
  - The butterfly pipeline is 2 cycles: cycle 1 = register twiddle product; cycle 2 = add/sub, shift, write back.
  - Each stage = 4 issue cycles + 2 drain cycles; no read-after-write across stages.
  - Total = 18 cycles, then → UNLOAD.
  - Stage s (span 1,2,4) uses twiddle exponent k·(4/span), with k = position within the group.
  - Twiddles: W0=(2^(TW_W-1)-1, 0), W1=(c,-c), W2=(0,-(2^(TW_W-1)-1)), W3=(-c,-c). In IFFT mode the imaginary parts are negated (conjugate).
- Arithmetic:
  - p = b·W as a full complex product.
  - Round p by adding 2^(TW_W-2), then arithmetic shift right by TW_W-1, keeping DATA_W+2 bits.
  - W0 bypasses the multiply: p = b exactly.
  - y0 = (a+p)>>>1 and y1 = (a−p)>>>1, arithmetic shift (floor), truncated to DATA_W.
  - Net scale is 1/8 in both modes: FFT gives X[k]/8; IFFT gives the exact inverse including 1/N.
- UNLOAD:
  - Outputs are emitted in natural order, idx 0..7.
  - out_valid=1; the data and idx are held stable until out_valid & out_ready.
  - out_last=1 with idx 7.
  - After the idx-7 transfer: → LOAD, in_ready=1 on the next cycle, out_valid=0.
- Backpressure:
  - out_ready held low stalls UNLOAD indefinitely with no data change.
  - in_valid low in LOAD simply pauses the load count.
- busy=1 in COMPUTE and UNLOAD.
- Minimum frame period = 8 + 18 + 8 = 34 cycles.

Optional Feature:
- Macro FFT_BITREV_OUT_EN.
- When defined:
  - UNLOAD emits memory addresses in linear order, i.e. bins in bit-reversed order 0,4,2,6,1,5,3,7.
  - out_idx carries the true bin number.
  - out_last is asserted with the 8th transfer, which is bin 7.
- When undefined: natural order as above.
- Data values are identical in both builds.

Test Plan:
- Impulse, FFT: x0=(800,0), others 0, in_inv=0 → all 8 outputs (100,0); out_idx 0..7; out_last only on idx 7.
- DC, FFT: all x=(800,0) → bin0 (800,0), bins 1–7 (0,0).
- IFFT: frame (800,0),0,...,0 with in_inv=1 → 8 outputs (100,0).
- Full-scale tone: x[n]=round(32767·(cos,sin)(2πn/8)) → bin1 within ±2 of (32767,0) after 1/8·8 gain; other bins |re|,|im| ≤ 2.
- Handshake stress: random in_valid gaps, out_ready low for 20 cycles mid-UNLOAD → output values unchanged; no sample lost or duplicated; in_ready=0 throughout COMPUTE/UNLOAD.
- Reset mid-COMPUTE: drive reset=0 for 1 cycle at COMPUTE cycle 9 → out_valid=0 and in_ready=1 immediately; a following clean impulse frame yields eight (100,0) outputs.
